// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin sharing of one single-port word RAM between
// the CPU port (0) and a loader/debug DMA port (1), each with a small request FIFO.
module mem_arbiter #(
    parameter int ADDR_W = 16,
    parameter int QDEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              p0_rd_en,
    input  logic              p0_wr_en,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [31:0]       p0_wr_data,
    output logic              p0_rd_valid,
    input  logic              p1_rd_en,
    input  logic              p1_wr_en,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [31:0]       p1_wr_data,
    output logic              p1_rd_valid,
    output logic [31:0]       rd_data,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-3:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    output logic [1:0]        err
);

    localparam int WA_W = ADDR_W - 2;
    localparam int PW   = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int CW   = $clog2(QDEPTH + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(QDEPTH);

    typedef struct packed {
        logic            we;
        logic [WA_W-1:0] waddr;
        logic [31:0]     wdata;
    } req_t;

    // Port-indexed views of the two requester buses
    logic [1:0]        rd_en;
    logic [1:0]        wr_en;
    logic [ADDR_W-1:0] addr_in  [2];
    logic [31:0]       wdata_in [2];
    req_t              in_req   [2];
    logic [1:0]        req_ok;
    logic [1:0]        req_bad;

    // Per-port FIFO state
    req_t          fifo_q [2][QDEPTH];
    logic [PW-1:0] rptr_q [2];
    logic [PW-1:0] rptr_d [2];
    logic [PW-1:0] wptr_q [2];
    logic [PW-1:0] wptr_d [2];
    logic [CW-1:0] cnt_q  [2];
    logic [CW-1:0] cnt_d  [2];

    // Arbiter, completion tag and sticky error state
    logic       last_q;
    logic       last_d;
    logic       tag_v_q;
    logic       tag_v_d;
    logic       tag_p_q;
    logic       tag_p_d;
    logic [1:0] err_q;
    logic [1:0] err_d;

    // Per-cycle control
    logic [1:0] q_ne;
    logic [1:0] head_v;
    req_t       head [2];
    logic [1:0] gnt;
    req_t       win;
    logic [1:0] pop;
    logic [1:0] bypass;
    logic [1:0] want;
    logic [1:0] push;
    logic [1:0] ovf;

    // Byte-offset bits are ignored by a word-wide RAM
    logic unused_addr_lsbs;

    assign rd_en       = {p1_rd_en, p0_rd_en};
    assign wr_en       = {p1_wr_en, p0_wr_en};
    assign addr_in[0]  = p0_addr;
    assign addr_in[1]  = p1_addr;
    assign wdata_in[0] = p0_wr_data;
    assign wdata_in[1] = p1_wr_data;
    assign unused_addr_lsbs = ^{p0_addr[1:0], p1_addr[1:0]};

    // Decode request pulses; anything presented during reset is ignored
    always_comb begin
        req_ok  = '0;
        req_bad = '0;
        for (int n = 0; n < 2; n++) begin
            req_ok[n]        = ~rst & (rd_en[n] ^ wr_en[n]);
            req_bad[n]       = ~rst & rd_en[n] & wr_en[n];
            in_req[n].we     = wr_en[n];
            in_req[n].waddr  = addr_in[n][ADDR_W-1:2];
            in_req[n].wdata  = wdata_in[n];
        end
    end

    // Effective head: stored FIFO head, else the incoming request (bypass)
    always_comb begin
        q_ne   = '0;
        head_v = '0;
        for (int n = 0; n < 2; n++) begin
            q_ne[n]   = (cnt_q[n] != '0);
            head_v[n] = ~rst & (q_ne[n] | req_ok[n]);
            head[n]   = q_ne[n] ? fifo_q[n][rptr_q[n]] : in_req[n];
        end
    end

    // Round-robin grant: on a tie the port not granted last wins
    always_comb begin
        gnt = '0;
        unique case (head_v)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = last_q ? 2'b01 : 2'b10;
            default: gnt = '0;
        endcase
    end

    // Winner drives the RAM combinationally; idle cycles drive zeros
    always_comb begin
        win = '0;
        if (gnt[1]) begin
            win = head[1];
        end else if (gnt[0]) begin
            win = head[0];
        end
        mem_en    = |gnt;
        mem_we    = win.we;
        mem_addr  = win.waddr;
        mem_wdata = win.wdata;
    end

    // FIFO bookkeeping: pop frees a slot before the push is checked
    always_comb begin
        pop    = '0;
        bypass = '0;
        want   = '0;
        ovf    = '0;
        push   = '0;
        for (int n = 0; n < 2; n++) begin
            pop[n]    = gnt[n] & q_ne[n];
            bypass[n] = gnt[n] & ~q_ne[n];
            want[n]   = req_ok[n] & ~bypass[n];
            ovf[n]    = want[n] & (cnt_q[n] == FULL_CNT) & ~pop[n];
            push[n]   = want[n] & ~ovf[n];
            cnt_d[n]  = cnt_q[n] + CW'(push[n]) - CW'(pop[n]);
            rptr_d[n] = rptr_q[n] + PW'(pop[n]);
            wptr_d[n] = wptr_q[n] + PW'(push[n]);
        end
    end

    // Next arbiter history, completion tag and sticky errors
    always_comb begin
        last_d = last_q;
        if (|gnt) begin
            last_d = gnt[1];
        end
        tag_v_d = (|gnt) & ~win.we;
        tag_p_d = gnt[1];
        err_d   = err_q | req_bad | ovf;
    end

    // Control state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int n = 0; n < 2; n++) begin
                rptr_q[n] <= '0;
                wptr_q[n] <= '0;
                cnt_q[n]  <= '0;
            end
            last_q  <= 1'b1;
            tag_v_q <= 1'b0;
            tag_p_q <= 1'b0;
            err_q   <= '0;
        end else begin
            for (int n = 0; n < 2; n++) begin
                rptr_q[n] <= rptr_d[n];
                wptr_q[n] <= wptr_d[n];
                cnt_q[n]  <= cnt_d[n];
            end
            last_q  <= last_d;
            tag_v_q <= tag_v_d;
            tag_p_q <= tag_p_d;
            err_q   <= err_d;
        end
    end

    // FIFO storage; contents are qualified by the occupancy counters
    always_ff @(posedge clk) begin
        for (int n = 0; n < 2; n++) begin
            if (push[n]) begin
                fifo_q[n][wptr_q[n]] <= in_req[n];
            end
        end
    end

    assign p0_rd_valid = ~rst & tag_v_q & ~tag_p_q;
    assign p1_rd_valid = ~rst & tag_v_q & tag_p_q;
    assign rd_data     = (~rst & tag_v_q) ? mem_rdata : '0;
    assign err         = err_q;

endmodule
